// File: rtl/serial_mag_compare_pkg.sv
// Shared constants and types for the bit-serial magnitude comparator:
// FSM state encoding, default operand width and result decoding.
package serial_mag_compare_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } result_t;

  // K/L flag pair to one-hot result; K=L=0 cannot occur, so it decodes to all-zero.
  function automatic result_t decode_flags(input logic k, input logic l);
    result_t res;
    res.gt = k & ~l;
    res.lt = ~k & l;
    res.eq = k & l;
    return res;
  endfunction

endpackage

// File: rtl/serial_mag_compare_cmp_slice.sv
// One-bit step of the MSB-first comparison: folds the current A/B bit pair
// into the running K (A>=B so far) and L (A<=B so far) flags.
module cmp_slice (
  input  logic i_k,
  input  logic i_l,
  input  logic i_a,
  input  logic i_b,
  output logic o_k_next,
  output logic o_l_next
);

  // Once one flag has dropped, the higher bit already decided the outcome and
  // the other flag must stay set; otherwise a differing bit pair clears one flag.
  assign o_k_next = ~i_l | (i_k & i_a) | (i_k & ~i_b);
  assign o_l_next = ~i_k | (i_l & i_b) | (i_l & ~i_a);

endmodule

// File: rtl/serial_mag_compare.sv
// Bit-serial unsigned magnitude comparator: captures A and B on start, walks
// them MSB first over WIDTH cycles, then pulses done with a one-hot gt/lt/eq.
module serial_mag_compare
  import serial_mag_compare_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_k;
  logic                 r_l;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  result_t              r_res;

  logic                 w_k_next;
  logic                 w_l_next;

  cmp_slice u_cmp_slice (
    .i_k      (r_k),
    .i_l      (r_l),
    .i_a      (r_a[WIDTH-1]),
    .i_b      (r_b[WIDTH-1]),
    .o_k_next (w_k_next),
    .o_l_next (w_l_next)
  );

  // NOTE: non-blocking assignments throughout, so every branch below reads the
  // pre-edge register values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand shift registers are ordinary flops, not a memory, so
      // they are reset with everything else to keep the post-reset state fully defined.
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= 1'b1;
      r_l     <= 1'b1;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_res   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_k     <= 1'b1;
            r_l     <= 1'b1;
            r_res   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cnt   <= CNT_W'(WIDTH - 1);
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_k <= w_k_next;
          r_l <= w_l_next;
          r_a <= {r_a[WIDTH-2:0], 1'b0};
          r_b <= {r_b[WIDTH-2:0], 1'b0};
          // Always runs all WIDTH bits; the result is taken from the final
          // slice output so it appears in the same cycle as the done pulse.
          if (r_cnt == '0) begin
            r_res   <= decode_flags(w_k_next, w_l_next);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign gt   = r_res.gt;
  assign lt   = r_res.lt;
  assign eq   = r_res.eq;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Scoreboard bench for serial_mag_compare: accepted starts push the integer
// comparison result and its due cycle; a negedge monitor pops and checks.
module tb_serial_mag_compare;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, gt, lt, eq;

  serial_mag_compare #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .lt    (lt),
    .eq    (eq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
    end
  endtask

  // Reference model: a start is taken only when WIDTH+3 edges have passed since
  // the previous acceptance; the result is due WIDTH+1 edges after acceptance.
  typedef struct {
    logic [2:0] flags;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  int         edge_cnt = 0;
  int         next_ok = 0;
  int         last_acc = 0;
  bit         acc_valid = 0;
  logic [2:0] exp_flags = 3'b000;
  logic [2:0] pend_flags = 3'b000;
  int         pend_due = 0;
  bit         pend_valid = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      next_ok    = edge_cnt + 1;
      acc_valid  = 0;
      pend_valid = 0;
      exp_flags  = 3'b000;
    end else begin
      edge_cnt++;
      if (pend_valid && edge_cnt == pend_due) begin
        exp_flags  = pend_flags;
        pend_valid = 0;
      end
      if (start && edge_cnt >= next_ok) begin
        exp_t e;
        e.flags    = {a_in > b_in, a_in < b_in, a_in == b_in};
        e.due      = edge_cnt + W + 1;
        exp_q.push_back(e);
        pend_flags = e.flags;
        pend_due   = e.due;
        pend_valid = 1;
        exp_flags  = 3'b000;
        last_acc   = edge_cnt;
        acc_valid  = 1;
        next_ok    = edge_cnt + W + 3;
      end
    end
  end

  // Monitor: every cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_done;
      bit exp_busy;
      exp_done = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
      exp_busy = acc_valid && (edge_cnt >= last_acc) && (edge_cnt <= last_acc + W);
      check("done", 32'(done), 32'(exp_done));
      check("busy", 32'(busy), 32'(exp_busy));
      check("flags_held", 32'({gt, lt, eq}), 32'(exp_flags));
      if (exp_done) begin
        check("result", 32'({gt, lt, eq}), 32'(exp_q[0].flags));
        check("onehot", 32'($countones({gt, lt, eq})), 32'd1);
        void'(exp_q.pop_front());
      end else if (exp_q.size() > 0 && exp_q[0].due < edge_cnt) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic one_compare(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    repeat (W + 3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({gt, lt, eq}), 32'd0);
    rst_n = 1'b1;

    // Directed cases with hand-derived results.
    one_compare(8'hA5, 8'h5A);
    check("a5_5a", 32'({gt, lt, eq}), 32'b100);
    one_compare(8'h3C, 8'h3C);
    check("3c_3c", 32'({gt, lt, eq}), 32'b001);
    one_compare(8'h80, 8'h81);
    check("80_81", 32'({gt, lt, eq}), 32'b010);
    one_compare(8'hFF, 8'h00);
    check("ff_00", 32'({gt, lt, eq}), 32'b100);
    one_compare(8'h00, 8'hFF);
    check("00_ff", 32'({gt, lt, eq}), 32'b010);

    // Abort during the 4th SHIFT cycle: outputs must clear at once.
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'hF0;
    b_in  = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_flags", 32'({gt, lt, eq}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    one_compare(8'h01, 8'h00);
    check("post_abort", 32'({gt, lt, eq}), 32'b100);

    // Start held high with operands changing every cycle.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b1;
      a_in  = W'($urandom);
      b_in  = (i % 3 == 0) ? a_in : W'($urandom);
    end

    // Random traffic, mostly back-to-back, biased toward equal operands.
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      start = ($urandom_range(9) != 0);
      a_in  = W'($urandom);
      b_in  = ($urandom_range(3) == 0) ? a_in : W'($urandom);
    end

    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
